// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one line-wide memory port between an I-cache and a D-cache.
// Grants alternate on conflict, and a one-cycle RELEASE gap separates back-to-back grants.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_read,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,

    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,

    output logic [ADDR_WIDTH-1:0] pmem_addr,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp,

    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  i_grant_cnt,
    output logic [CNT_WIDTH-1:0]  d_grant_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic LAST_I = 1'b0;
    localparam logic LAST_D = 1'b1;

    state_t                  state_q, state_d;
    logic                    last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LINE_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    rd_q, rd_d;
    logic                    wr_q, wr_d;
    logic [CNT_WIDTH-1:0]    i_cnt_q, i_cnt_d;
    logic [CNT_WIDTH-1:0]    d_cnt_q, d_cnt_d;
    logic                    d_req;

    assign d_req = d_read | d_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= LAST_I;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            i_cnt_q      <= '0;
            d_cnt_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            i_cnt_q      <= i_cnt_d;
            d_cnt_q      <= d_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        i_cnt_d      = i_cnt_q;
        d_cnt_d      = d_cnt_q;
        i_resp       = 1'b0;
        d_resp       = 1'b0;

        case (state_q)
            IDLE: begin
                // On conflict the requester that was not served last wins.
                if (d_req && (!i_read || last_grant_q == LAST_I)) begin
                    state_d = GRANT_D;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    wr_d    = d_write;
                    rd_d    = ~d_write;
                end else if (i_read) begin
                    state_d = GRANT_I;
                    addr_d  = i_addr;
                    wdata_d = '0;
                    wr_d    = 1'b0;
                    rd_d    = 1'b1;
                end
            end
            GRANT_I: begin
                i_resp = pmem_resp;
                if (pmem_resp) begin
                    state_d      = RELEASE;
                    last_grant_d = LAST_I;
                    rd_d         = 1'b0;
                    wr_d         = 1'b0;
                    i_cnt_d      = (&i_cnt_q) ? i_cnt_q : i_cnt_q + CNT_WIDTH'(1);
                end
            end
            GRANT_D: begin
                d_resp = pmem_resp;
                if (pmem_resp) begin
                    state_d      = RELEASE;
                    last_grant_d = LAST_D;
                    rd_d         = 1'b0;
                    wr_d         = 1'b0;
                    d_cnt_d      = (&d_cnt_q) ? d_cnt_q : d_cnt_q + CNT_WIDTH'(1);
                end
            end
            RELEASE: begin
                // One dead cycle lets a requester drop its request before re-arbitration.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign i_rdata     = pmem_rdata;
    assign d_rdata     = pmem_rdata;
    assign pmem_addr   = addr_q;
    assign pmem_wdata  = wdata_q;
    assign pmem_read   = rd_q;
    assign pmem_write  = wr_q;
    assign busy        = (state_q != IDLE);
    assign i_grant_cnt = i_cnt_q;
    assign d_grant_cnt = d_cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a transaction-level model predicts the winner,
// the held memory request, the response pulse and the saturating grant counters.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;
    localparam int CW = 4;
    localparam int CNT_MAX = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] i_addr = '0;
    logic          i_read = 1'b0;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic [AW-1:0] d_addr = '0;
    logic          d_read = 1'b0;
    logic          d_write = 1'b0;
    logic [LW-1:0] d_wdata = '0;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic [AW-1:0] pmem_addr;
    logic          pmem_read;
    logic          pmem_write;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata = '0;
    logic          pmem_resp = 1'b0;
    logic          busy;
    logic [CW-1:0] i_grant_cnt;
    logic [CW-1:0] d_grant_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: who was served last, and how many completions each side has.
    bit m_last_d = 1'b0;
    int m_icnt   = 0;
    int m_dcnt   = 0;

    mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_addr(pmem_addr), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .busy(busy), .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int k = 0; k < LW / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic int sat_inc(input int c);
        return (c < CNT_MAX) ? c + 1 : c;
    endfunction

    task automatic check_counters(input string tag);
        check({tag, "_icnt"}, i_grant_cnt, m_icnt);
        check({tag, "_dcnt"}, d_grant_cnt, m_dcnt);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_txn(input bit ir, input bit dr, input bit dw,
                           input logic [AW-1:0] ia, input logic [AW-1:0] da,
                           input logic [LW-1:0] wd, input int lat,
                           input bit drop, input bit idle_resp);
        bit            win_d;
        logic [AW-1:0] e_addr;
        logic [LW-1:0] e_wdata;
        bit            e_rd, e_wr;
        logic [LW-1:0] rdata;

        win_d   = (dr | dw) && (!ir || !m_last_d);
        e_addr  = win_d ? da : ia;
        e_wdata = win_d ? wd : '0;
        e_wr    = win_d && dw;
        e_rd    = !e_wr;

        i_read = ir; d_read = dr; d_write = dw;
        i_addr = ia; d_addr = da; d_wdata = wd;
        pmem_resp = 1'b0;

        @(posedge clk); #1;
        check("grant_busy", busy, 1'b1);
        check("grant_rd", pmem_read, e_rd);
        check("grant_wr", pmem_write, e_wr);
        check("grant_addr", pmem_addr, e_addr);
        check("grant_wdata", pmem_wdata, e_wdata);

        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            if (drop) begin
                i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
                i_addr = $urandom; d_addr = $urandom; d_wdata = rand_line();
            end
            @(posedge clk); #1;
            check("hold_rd", pmem_read, e_rd);
            check("hold_wr", pmem_write, e_wr);
            check("hold_addr", pmem_addr, e_addr);
            check("hold_wdata", pmem_wdata, e_wdata);
            check("hold_iresp", i_resp, 1'b0);
            check("hold_dresp", d_resp, 1'b0);
        end

        @(negedge clk);
        rdata = rand_line();
        pmem_rdata = rdata;
        pmem_resp = 1'b1;
        #1;
        check("resp_i", i_resp, !win_d);
        check("resp_d", d_resp, win_d);
        check("resp_irdata", i_rdata, rdata);
        check("resp_drdata", d_rdata, rdata);
        check("resp_addr", pmem_addr, e_addr);

        @(posedge clk); #1;
        m_last_d = win_d;
        if (win_d) m_dcnt = sat_inc(m_dcnt);
        else       m_icnt = sat_inc(m_icnt);
        // pmem_resp is still high here and must be ignored in the gap cycle
        check("rel_busy", busy, 1'b1);
        check("rel_strobes", {pmem_read, pmem_write}, 2'b00);
        check("rel_resp", {i_resp, d_resp}, 2'b00);
        check_counters("rel");

        @(negedge clk);
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        pmem_resp = 1'b0;
        @(posedge clk); #1;
        check("idle_busy", busy, 1'b0);
        check("idle_strobes", {pmem_read, pmem_write}, 2'b00);

        @(negedge clk);
        pmem_resp = idle_resp;
        #1;
        check("idle_resp", {i_resp, d_resp}, 2'b00);
        @(posedge clk); #1;
        check("idle_busy2", busy, 1'b0);
        check_counters("idle");
        @(negedge clk);
        pmem_resp = 1'b0;
        $display("txn ir=%0b dr=%0b dw=%0b lat=%0d drop=%0b -> %s addr=%h icnt=%0d dcnt=%0d",
                 ir, dr, dw, lat, drop, win_d ? "D" : "I", e_addr, m_icnt, m_dcnt);
    endtask

    initial begin
        logic [LW-1:0] a5;
        bit ir, dr, dw;

        for (int k = 0; k < LW / 8; k++) a5[k*8 +: 8] = 8'hA5;

        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_strobes", {pmem_read, pmem_write}, 2'b00);
        check("rst_addr", pmem_addr, '0);
        check("rst_wdata", pmem_wdata, '0);
        check("rst_resp", {i_resp, d_resp}, 2'b00);
        check_counters("rst");
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_txn(1, 0, 0, 32'h0000_1000, 32'h0, '0, 3, 0, 0);
        // conflicts alternate starting with D
        run_txn(1, 1, 0, 32'h0000_2000, 32'h0000_3000, rand_line(), 1, 0, 0);
        run_txn(1, 1, 0, 32'h0000_2040, 32'h0000_3040, rand_line(), 0, 0, 1);
        run_txn(1, 1, 0, 32'h0000_2080, 32'h0000_3080, rand_line(), 2, 0, 0);
        run_txn(0, 0, 1, 32'h0, 32'h8000_0040, a5, 2, 0, 0);
        run_txn(0, 1, 1, 32'h0, 32'h8000_0040, a5, 2, 0, 0);
        run_txn(0, 1, 0, 32'h0, 32'h0000_5000, rand_line(), 2, 1, 0);
        run_txn(1, 0, 0, 32'h0000_6000, 32'h0, '0, 2, 1, 1);

        for (int t = 0; t < 60; t++) begin
            do begin
                ir = $urandom_range(0, 1);
                dr = $urandom_range(0, 1);
                dw = $urandom_range(0, 1);
            end while (!(ir | dr | dw));
            run_txn(ir, dr, dw, $urandom, $urandom, rand_line(),
                    $urandom_range(0, 4), $urandom_range(0, 1), $urandom_range(0, 1));
        end

        // Leave last_grant = D, then reset in the middle of a D grant.
        run_txn(0, 1, 0, 32'h0, 32'h0000_7000, rand_line(), 0, 0, 0);
        d_read = 1'b1; d_addr = 32'h0000_9000;
        @(posedge clk); #1;
        check("rg_rd", pmem_read, 1'b1);
        @(negedge clk);
        pmem_resp = 1'b1;
        rst = 1'b1;
        #1;
        check("rg_busy", busy, 1'b0);
        check("rg_strobes", {pmem_read, pmem_write}, 2'b00);
        check("rg_addr", pmem_addr, '0);
        check("rg_resp", {i_resp, d_resp}, 2'b00);
        check("rg_icnt", i_grant_cnt, 0);
        check("rg_dcnt", d_grant_cnt, 0);
        m_last_d = 1'b0; m_icnt = 0; m_dcnt = 0;
        d_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            check("pr_resp", {i_resp, d_resp}, 2'b00);
            check("pr_busy", busy, 1'b0);
            check_counters("pr");
        end
        @(negedge clk);
        pmem_resp = 1'b0;
        run_txn(1, 1, 0, 32'h0000_A000, 32'h0000_B000, rand_line(), 1, 0, 0);

        for (int t = 0; t < 20; t++)
            run_txn(1, 0, 0, $urandom, 32'h0, '0, $urandom_range(0, 2), 0, 0);
        check("sat_icnt", i_grant_cnt, 4'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, physical address width.
REQ-002 Parameter LINE_WIDTH, default 256, cache line width in bits.
REQ-003 Parameter CNT_WIDTH, default 16, width of each grant counter.
REQ-004 clk  input  1  sole clock, rising-edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 i_addr  input  ADDR_WIDTH  I-cache miss line address.
REQ-007 i_read  input  1  I-cache line read request.
REQ-008 i_rdata  output  LINE_WIDTH  line returned to I-cache.
REQ-009 i_resp  output  1  I-cache transaction complete.
REQ-010 d_addr  input  ADDR_WIDTH  D-cache line address.
REQ-011 d_read  input  1  D-cache line read request.
REQ-012 d_write  input  1  D-cache line writeback request.
REQ-013 d_wdata  input  LINE_WIDTH  D-cache writeback line.
REQ-014 d_rdata  output  LINE_WIDTH  line returned to D-cache.
REQ-015 d_resp  output  1  D-cache transaction complete.
REQ-016 pmem_addr  output  ADDR_WIDTH  shared memory address.
REQ-017 pmem_read  output  1  shared memory read strobe.
REQ-018 pmem_write  output  1  shared memory write strobe.
REQ-019 pmem_wdata  output  LINE_WIDTH  shared memory write line.
REQ-020 pmem_rdata  input  LINE_WIDTH  shared memory read line.
REQ-021 pmem_resp  input  1  shared memory transaction complete.
REQ-022 busy  output  1  high whenever state is not IDLE.
REQ-023 i_grant_cnt  output  CNT_WIDTH  completed I transactions, saturating.
REQ-024 d_grant_cnt  output  CNT_WIDTH  completed D transactions, saturating.

Function
REQ-025 FSM SHALL have states IDLE, GRANT_I, GRANT_D, RELEASE.
REQ-026 IDLE: D request only (d_read|d_write) -> GRANT_D; i_read only -> GRANT_I; none -> stay IDLE.
REQ-027 IDLE with both pending SHALL grant the requester not recorded in last_grant; last_grant resets to I, so D wins the first conflict.
REQ-028 On entry to GRANT_x, pmem_addr/pmem_wdata/pmem_read/pmem_write SHALL be registered from requester x and held constant until pmem_resp; pmem strobes assert the cycle after the request is sampled in IDLE (latency 1).
REQ-029 GRANT_I SHALL drive pmem_read=1, pmem_write=0, pmem_wdata=0.
REQ-030 GRANT_D with d_write=1 SHALL drive pmem_write=1, pmem_read=0 (write wins if d_read and d_write both high); otherwise pmem_read=1.
REQ-031 In GRANT_x, pmem_resp SHALL assert x_resp combinationally in the same cycle; the other requester's resp stays 0.
REQ-032 i_rdata and d_rdata SHALL both equal pmem_rdata at all times; only resp qualifies them.
REQ-033 On pmem_resp in GRANT_x: next state RELEASE, last_grant<=x, x_grant_cnt increments unless all-ones.
REQ-034 RELEASE SHALL hold all pmem strobes and both resp low for one cycle, then go IDLE, so a requester deasserting after resp is never re-granted.
REQ-035 Requester deasserting mid-grant SHALL NOT cancel the transaction; grant holds until pmem_resp, and resp is still pulsed.
REQ-036 pmem_resp in IDLE or RELEASE SHALL be ignored (no resp, no counter change, no state change).
REQ-037 Minimum back-to-back spacing: resp cycle N, next pmem strobe no earlier than N+3.

Reset
REQ-038 rst high SHALL immediately force IDLE, last_grant=I, pmem_read=pmem_write=0, pmem_addr=0, pmem_wdata=0, i_resp=d_resp=0, busy=0, both counters 0.
REQ-039 Reset asserted during GRANT_x SHALL abort without resp; first post-reset request is arbitrated afresh.

Verification
REQ-040 i_read, i_addr=0x0000_1000, pmem_resp after 4 cycles -> pmem_read high cycle 1..4, pmem_addr=0x1000, i_resp one cycle with pmem_resp, i_grant_cnt=1, d_resp never.
REQ-041 i_read and d_read same cycle after reset -> D granted first; after D resp + RELEASE, I granted; then both again -> D first (alternation from last_grant=I).
REQ-042 d_write, d_addr=0x8000_0040, d_wdata=all 0xA5 -> pmem_write=1, pmem_read=0, pmem_wdata held all 0xA5 until resp; d_read+d_write together behaves identically.
REQ-043 Requester drops request mid-grant, pmem_resp 3 cycles later -> pmem strobes held until resp, resp pulsed once, state RELEASE then IDLE.
REQ-044 rst pulsed while GRANT_D active -> outputs clear asynchronously before next edge, counters 0, no d_resp; pmem_resp stimulus in IDLE ignored.
REQ-045 Counter force-preloaded near all-ones (CNT_WIDTH=4), 20 I transactions -> i_grant_cnt stops at 0xF.
